// File: rtl/bitser_pkg.sv
// Shared definitions for the bit-serial datapath controllers: sequencer state
// encoding and a small state-class helper.
package bitser_pkg;

    localparam int SEQ_STATE_W = 3;

    typedef enum logic [SEQ_STATE_W-1:0] {
        SEQ_IDLE  = 3'd0,
        SEQ_LOAD  = 3'd1,
        SEQ_PRIME = 3'd2,
        SEQ_SHIFT = 3'd3,
        SEQ_DONE  = 3'd4
    } seq_state_t;

    // PRIME and SHIFT are the states in which the serial datapath is moving.
    function automatic logic is_serial(input seq_state_t s);
        return (s == SEQ_PRIME) || (s == SEQ_SHIFT);
    endfunction

endpackage

// File: rtl/bit_counter.sv
// Bit-index counter for the serial sequencer; terminal flags index WIDTH-1.
module bit_counter
    import bitser_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    output logic [IDX_W-1:0] count,
    output logic             terminal
);

    logic [IDX_W-1:0] r_count;

    // NOTE: state registers use non-blocking assignments and an asynchronous,
    // active-low reset so every flop clears the moment rst_n falls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count    = r_count;
    assign terminal = (r_count == IDX_W'(WIDTH - 1));

endmodule

// File: rtl/serial_seq_ctrl.sv
// Bit-serial operation sequencer: LOAD, PRIME, WIDTH SHIFT cycles, DONE.
// Define SERIAL_SEQ_STALL_EN to let stall insert bubbles in PRIME/SHIFT.
module serial_seq_ctrl
    import bitser_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic             stall,
    output logic             sr_en,
    output logic             sr_load,
    output logic             alu_first,
    output logic             wb_en,
    output logic [IDX_W-1:0] bit_idx,
    output logic             last_bit,
    output logic             busy,
    output logic             done
);

    seq_state_t       r_state;
    logic             r_bubble;
    logic             r_sr_en;
    logic             r_sr_load;
    logic             r_alu_first;
    logic             r_wb_en;
    logic             r_last_bit;
    logic             r_busy;
    logic             r_done;

    seq_state_t       w_nxt_state;
    logic             w_nxt_bubble;
    logic             w_nxt_work;
    logic             w_nxt_last;
    logic             w_accept;
    logic             w_cnt_en;
    logic             w_cnt_clr;
    logic             w_term;
    logic             w_pre_term;
    logic [IDX_W-1:0] w_count;

    assign start_ready = (r_state == SEQ_IDLE) || (r_state == SEQ_DONE);
    assign w_accept    = start_valid && start_ready;
    assign w_pre_term  = (w_count == IDX_W'(WIDTH - 2));

    bit_counter #(.WIDTH(WIDTH)) u_bit_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (w_cnt_en),
        .clr      (w_cnt_clr),
        .count    (w_count),
        .terminal (w_term)
    );

    // A bubble cycle did no serial work, so PRIME/SHIFT repeat it rather than advance.
    // NOTE: every signal gets a default at the top of always_comb so no path
    // through the case can leave it unassigned and infer a latch.
    always_comb begin
        w_nxt_state = r_state;
        w_cnt_en    = 1'b0;
        w_cnt_clr   = 1'b0;
        case (r_state)
            SEQ_IDLE:  if (w_accept) w_nxt_state = SEQ_LOAD;
            SEQ_LOAD:  w_nxt_state = SEQ_PRIME;
            SEQ_PRIME: if (!r_bubble) w_nxt_state = SEQ_SHIFT;
            SEQ_SHIFT: begin
                if (!r_bubble) begin
                    if (w_term) begin
                        w_nxt_state = SEQ_DONE;
                        w_cnt_clr   = 1'b1;
                    end else begin
                        w_cnt_en    = 1'b1;
                    end
                end
            end
            SEQ_DONE:  w_nxt_state = w_accept ? SEQ_LOAD : SEQ_IDLE;
            default:   w_nxt_state = SEQ_IDLE;
        endcase
    end

`ifdef SERIAL_SEQ_STALL_EN
    // Stall seen in a serial cycle turns the following serial cycle into a bubble.
    assign w_nxt_bubble = stall && is_serial(r_state) && is_serial(w_nxt_state);
`else
    logic w_unused_stall;
    assign w_unused_stall = stall;
    assign w_nxt_bubble   = 1'b0;
`endif

    assign w_nxt_work = is_serial(w_nxt_state) && !w_nxt_bubble;
    assign w_nxt_last = (w_nxt_state == SEQ_SHIFT) && !w_nxt_bubble &&
                        (w_cnt_en ? w_pre_term : w_term);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= SEQ_IDLE;
            r_bubble    <= 1'b0;
            r_sr_en     <= 1'b0;
            r_sr_load   <= 1'b0;
            r_alu_first <= 1'b0;
            r_wb_en     <= 1'b0;
            r_last_bit  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_nxt_state;
            r_bubble    <= w_nxt_bubble;
            r_sr_en     <= (w_nxt_state == SEQ_LOAD) || w_nxt_work;
            r_sr_load   <= (w_nxt_state == SEQ_LOAD);
            r_alu_first <= (w_nxt_state == SEQ_PRIME);
            r_wb_en     <= (w_nxt_state == SEQ_SHIFT) && !w_nxt_bubble;
            r_last_bit  <= w_nxt_last;
            r_busy      <= (w_nxt_state != SEQ_IDLE);
            r_done      <= (w_nxt_state == SEQ_DONE);
        end
    end

    assign sr_en     = r_sr_en;
    assign sr_load   = r_sr_load;
    assign alu_first = r_alu_first;
    assign wb_en     = r_wb_en;
    assign bit_idx   = w_count;
    assign last_bit  = r_last_bit;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_serial_seq_ctrl.sv
// Scoreboarded bench for serial_seq_ctrl driving a bit-serial shift-register/ALU plant.
// Honours SERIAL_SEQ_STALL_EN for the stall scenario's expected timing.
module tb_serial_seq_ctrl;

    localparam int WIDTH = 8;
    localparam int IDX_W = 3;
    localparam int LAT   = WIDTH + 3;
`ifdef SERIAL_SEQ_STALL_EN
    localparam int STALL_LAT = WIDTH + 6;
`else
    localparam int STALL_LAT = WIDTH + 3;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start_valid;
    logic             start_ready;
    logic             stall;
    logic             sr_en;
    logic             sr_load;
    logic             alu_first;
    logic             wb_en;
    logic [IDX_W-1:0] bit_idx;
    logic             last_bit;
    logic             busy;
    logic             done;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int q_lat[$];
    int q_acc[$];
    int q_idx[$];

    serial_seq_ctrl #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .stall       (stall),
        .sr_en       (sr_en),
        .sr_load     (sr_load),
        .alu_first   (alu_first),
        .wb_en       (wb_en),
        .bit_idx     (bit_idx),
        .last_bit    (last_bit),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Plant: operand 8'hA5 shifts out LSB first through a one-cycle ALU stage
    // whose key makes the serial result 8'h3C; results shift back in at the MSB.
    logic [7:0] key_v = 8'hA5 ^ 8'h3C;
    logic [7:0] p_sr;
    logic       p_d;
    logic [3:0] p_k;
    logic       w_key_bit;
    assign w_key_bit = alu_first ? key_v[0] : key_v[p_k[2:0]];

    always @(posedge clk) begin
        if (sr_load) begin
            p_sr <= 8'hA5;
        end else if (sr_en) begin
            p_sr <= {(wb_en ? p_d : 1'b0), p_sr[7:1]};
            p_d  <= p_sr[0] ^ w_key_bit;
            p_k  <= alu_first ? 4'd1 : p_k + 4'd1;
        end
    end

    // Scoreboard monitor: accepts, written indices and completion latency.
    initial begin
        int e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (start_valid && start_ready) q_acc.push_back(cyc);
                if (wb_en) begin
                    total++;
                    if (q_idx.size() == 0) begin
                        bad++;
                        $display("FAIL wb_idx: unexpected write at idx %0d", bit_idx);
                    end else begin
                        e = q_idx.pop_front();
                        if (bit_idx !== IDX_W'(e) || last_bit !== (e == WIDTH - 1)) begin
                            bad++;
                            $display("FAIL wb_idx: got idx=%0d last=%b, want idx=%0d last=%b",
                                     bit_idx, last_bit, e, (e == WIDTH - 1));
                        end
                    end
                end
                if (done) begin
                    total++;
                    if (q_lat.size() == 0 || q_acc.size() == 0) begin
                        bad++;
                        $display("FAIL done_lat: unexpected done at cycle %0d", cyc);
                    end else begin
                        e = q_lat.pop_front();
                        if (cyc - q_acc[0] !== e) begin
                            bad++;
                            $display("FAIL done_lat: got %0d cycles, want %0d", cyc - q_acc[0], e);
                        end
                        void'(q_acc.pop_front());
                    end
                    total++;
                    if (p_sr !== 8'h3C) begin
                        bad++;
                        $display("FAIL shift_reg: got %h, want 3c", p_sr);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic push_op(input int lat);
        q_lat.push_back(lat);
        for (int i = 0; i < WIDTH; i++) q_idx.push_back(i);
    endtask

    task automatic pulse_start();
        @(posedge clk); #2 start_valid = 1'b1;
        @(posedge clk); #2 start_valid = 1'b0;
    endtask

    task automatic wait_done(input int max, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL %s: done not seen within %0d cycles", name, max);
        end
    endtask

    task automatic wait_wb_idx(input int idx, input int max);
        bit seen = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (wb_en && bit_idx == IDX_W'(idx)) begin
                seen = 1'b1;
                break;
            end
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL wait_idx: idx %0d never written within %0d cycles", idx, max);
        end
    endtask

    task automatic count_dones(input int cycles, input string name);
        int n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done) n++;
        end
        total++;
        if (n !== 0) begin
            bad++;
            $display("FAIL %s: got %0d done pulses, want 0", name, n);
        end
    endtask

    function automatic logic [10:0] out_vec();
        return {sr_en, sr_load, alu_first, wb_en, last_bit, busy, done, start_ready, bit_idx};
    endfunction

    task automatic test_reset();
        logic [10:0] want = 11'b0000000_1_000;
        rst_n = 1'b0; start_valid = 1'b0; stall = 1'b0;
        #12;
        total++;
        if (out_vec() !== want) begin
            bad++;
            $display("FAIL reset_state: got %b, want %b", out_vec(), want);
        end
        @(posedge clk); #2 rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (out_vec() !== want) begin
            bad++;
            $display("FAIL idle_after_reset: got %b, want %b", out_vec(), want);
        end
    endtask

    task automatic test_single(input string name);
        logic [5:0] obs;
        push_op(LAT);
        pulse_start();
        @(negedge clk);
        obs = {sr_en, sr_load, alu_first, wb_en, busy, start_ready};
        total++;
        if (obs !== 6'b110010) begin
            bad++;
            $display("FAIL %s_load: got %b, want 110010", name, obs);
        end
        @(negedge clk);
        obs = {sr_en, sr_load, alu_first, wb_en, busy, start_ready};
        total++;
        if (obs !== 6'b101010) begin
            bad++;
            $display("FAIL %s_prime: got %b, want 101010", name, obs);
        end
        wait_done(40, name);
        @(negedge clk);
        total++;
        if ({busy, start_ready, done} !== 3'b010) begin
            bad++;
            $display("FAIL %s_idle: got busy/ready/done=%b, want 010", name, {busy, start_ready, done});
        end
    endtask

    task automatic test_back_to_back();
        int nload = 0, ndone = 0, prev = -1;
        bit chk_load = 1'b0;
        for (int k = 0; k < 3; k++) push_op(LAT);
        @(posedge clk); #2 start_valid = 1'b1;
        for (int i = 0; i < 80 && ndone < 3; i++) begin
            @(negedge clk);
            if (chk_load) begin
                chk_load = 1'b0;
                total++;
                if (sr_load !== 1'b1) begin
                    bad++;
                    $display("FAIL b2b_next_load: got sr_load=%b after done, want 1", sr_load);
                end
            end
            if (done) begin
                ndone++;
                if (prev >= 0) begin
                    total++;
                    if (cyc - prev - 1 !== 10) begin
                        bad++;
                        $display("FAIL b2b_period: got %0d cycles between dones, want 10", cyc - prev - 1);
                    end
                end
                prev = cyc;
                if (ndone < 3) chk_load = 1'b1;
            end
            if (sr_load) nload++;
            if (nload == 3 && start_valid) #2 start_valid = 1'b0;
        end
        start_valid = 1'b0;
        total++;
        if (ndone !== 3) begin
            bad++;
            $display("FAIL b2b_count: got %0d dones, want 3", ndone);
        end
        @(negedge clk);
    endtask

    task automatic test_ignore();
        push_op(LAT);
        pulse_start();
        wait_wb_idx(3, 20);
        #2 start_valid = 1'b1;
        total++;
        if (start_ready !== 1'b0) begin
            bad++;
            $display("FAIL ignore_ready: got start_ready=%b in SHIFT, want 0", start_ready);
        end
        @(posedge clk); #2 start_valid = 1'b0;
        wait_done(40, "ignore");
        count_dones(15, "ignore_extra");
    endtask

    task automatic test_reset_mid();
        logic [10:0] want = 11'b0000000_1_000;
        push_op(LAT);
        pulse_start();
        wait_wb_idx(5, 20);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (out_vec() !== want) begin
            bad++;
            $display("FAIL reset_mid: got %b, want %b", out_vec(), want);
        end
        q_lat.delete(); q_idx.delete(); q_acc.delete();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        count_dones(15, "reset_no_done");
        test_single("restart");
    endtask

    task automatic test_stall();
        logic [4:0] want;
        push_op(STALL_LAT);
        pulse_start();
        wait_wb_idx(1, 20);
        #2 stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
`ifdef SERIAL_SEQ_STALL_EN
            want = {2'b00, 3'd2};
`else
            want = {2'b11, 3'(2 + k)};
`endif
            total++;
            if ({sr_en, wb_en, bit_idx} !== want) begin
                bad++;
                $display("FAIL stall_hold: got sr_en/wb_en/idx=%b, want %b", {sr_en, wb_en, bit_idx}, want);
            end
        end
        #2 stall = 1'b0;
        wait_done(40, "stall");
    endtask

    initial begin
        test_reset();
        test_single("single");
        test_back_to_back();
        test_ignore();
        test_reset_mid();
        test_stall();
        repeat (3) @(negedge clk);
        total++;
        if (q_lat.size() !== 0 || q_idx.size() !== 0) begin
            bad++;
            $display("FAIL scoreboard_drain: %0d latencies and %0d indices left",
                     q_lat.size(), q_idx.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
